// File: rtl/common_types_pkg.sv
// Shared types for the flash read arbiter slice.
//   arb_state_t            : arbiter FSM states
//   RESP_OKAY / RESP_SLVERR: AXI read response codes
package common_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   clk, nrst     : clock, asynchronous active-low reset
//   req_i[1:0]    : request vector (bit 0 = M0, bit 1 = M1)
//   upd_i         : strobe recording upd_idx_i as the last granted index
//   upd_idx_i     : index that was just served
//   gnt_valid_o   : at least one request present
//   gnt_idx_o     : winning index (valid when gnt_valid_o)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // Resets to 1 so that M0 wins the first tie.
  logic last_grant_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_grant_q <= 1'b1;
    end else if (upd_i) begin
      last_grant_q <= upd_idx_i;
    end
  end

  always_comb begin
    gnt_valid_o = |req_i;
    unique case (req_i)
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_grant_q;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_flash_read_arbiter.sv
// Shares one read-only flash AXI read channel between two AXI read managers
// (M0 instruction fetch, M1 data load). Round-robin, one transaction in flight;
// the flash response is registered and returned with the requester's own ID.
//   clk, nrst           : clock, asynchronous active-low reset
//   m0_* / m1_*         : manager AR and R channels (rlast tied high)
//   s_*                 : flash controller AR and R channels (s_rid ignored)
// Optional: define FLASH_ARB_LAST_WORD_CACHE_EN to add a one-entry buffer of the
// last OKAY flash word; a matching request is answered without a flash access.
module axi_flash_read_arbiter
  import common_types_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [ID_W-1:0]   m0_rid,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ID_W-1:0]   m1_rid,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [1:0]        s_rresp
);

  arb_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ID_W-1:0]   id_q;
  logic              gidx_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic              win_valid;
  logic              win_idx;
  logic              accept;
  logic              upd;
  logic              hit;
  logic [ADDR_W-1:0] req_addr;
  logic [ID_W-1:0]   req_id;

  logic unused_bits;
  assign unused_bits = ^{s_rid, m0_araddr[1:0], m1_araddr[1:0]};

  assign upd = (state_q == RESP) && (gidx_q ? m1_rready : m0_rready);

  rr_arbiter2 u_rr_arbiter2 (
    .clk         (clk),
    .nrst        (nrst),
    .req_i       ({m1_arvalid, m0_arvalid}),
    .upd_i       (upd),
    .upd_idx_i   (gidx_q),
    .gnt_valid_o (win_valid),
    .gnt_idx_o   (win_idx)
  );

  always_comb begin
    accept   = (state_q == IDLE) && win_valid;
    req_addr = win_idx ? {m1_araddr[ADDR_W-1:2], 2'b00} : {m0_araddr[ADDR_W-1:2], 2'b00};
    req_id   = win_idx ? m1_arid : m0_arid;
  end

  assign m0_arready = accept && !win_idx;
  assign m1_arready = accept && win_idx;

`ifdef FLASH_ARB_LAST_WORD_CACHE_EN
  logic              cache_vld_q;
  logic [ADDR_W-3:0] cache_tag_q;
  logic [DATA_W-1:0] cache_data_q;

  assign hit = cache_vld_q && (cache_tag_q == req_addr[ADDR_W-1:2]);

  // Refreshed on every flash capture; an error response invalidates the entry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cache_vld_q  <= 1'b0;
      cache_tag_q  <= '0;
      cache_data_q <= '0;
    end else if (state_q == WAIT && s_rvalid) begin
      if (s_rresp == RESP_OKAY) begin
        cache_vld_q  <= 1'b1;
        cache_tag_q  <= addr_q[ADDR_W-1:2];
        cache_data_q <= s_rdata;
      end else begin
        cache_vld_q  <= 1'b0;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      gidx_q  <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            id_q   <= req_id;
            gidx_q <= win_idx;
            if (hit) begin
`ifdef FLASH_ARB_LAST_WORD_CACHE_EN
              rdata_q <= cache_data_q;
`endif
              rresp_q <= RESP_OKAY;
              state_q <= RESP;
            end else begin
              state_q <= ADDR;
            end
          end
        end
        ADDR: begin
          if (s_arready) state_q <= WAIT;
        end
        WAIT: begin
          if (s_rvalid) begin
            rdata_q <= s_rdata;
            rresp_q <= s_rresp;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (upd) state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_arvalid = (state_q == ADDR);
  assign s_araddr  = addr_q;
  assign s_arid    = id_q;
  assign s_rready  = (state_q == WAIT);

  assign m0_rvalid = (state_q == RESP) && !gidx_q;
  assign m1_rvalid = (state_q == RESP) && gidx_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign m0_rid    = id_q;
  assign m1_rid    = id_q;
  assign m0_rresp  = rresp_q;
  assign m1_rresp  = rresp_q;
  assign m0_rlast  = 1'b1;
  assign m1_rlast  = 1'b1;

endmodule

// File: doc/axi_flash_read_arbiter.md
Name: axi_flash_read_arbiter

Overview:
- Shares the single read-only flash controller between two AXI read managers: M0 (instruction fetch) and M1 (data load port).
- Sits between the core's two read ports and the flash controller's AXI read channel.
- Round-robin arbitration, one outstanding transaction at a time.
- Captures each response in a register and returns it to the granted manager with that manager's own ID.

Parameters:
- ADDR_W, 32, address width of AR channels
- DATA_W, 32, read data width
- ID_W, 4, AXI ID width on all ports

Ports:
- clk  input  1  system clock
- nrst  input  1  reset, asynchronous, active-low
- m0_arvalid  input  1  M0 read address valid
- m0_arready  output  1  M0 read address ready
- m0_araddr  input  ADDR_W  M0 read address
- m0_arid  input  ID_W  M0 read ID
- m0_rvalid  output  1  M0 read data valid
- m0_rready  input  1  M0 read data ready
- m0_rdata  output  DATA_W  M0 read data
- m0_rid  output  ID_W  M0 read ID returned
- m0_rresp  output  2  M0 read response
- m0_rlast  output  1  always 1
- m1_* (10 signals)  same directions/widths as m0_*  same meanings for M1
- s_arvalid  output  1  flash read address valid
- s_arready  input  1  flash read address ready
- s_araddr  output  ADDR_W  flash read address
- s_arid  output  ID_W  flash read ID
- s_rvalid  input  1  flash read data valid
- s_rready  output  1  flash read data ready
- s_rdata  input  DATA_W  flash read data
- s_rid  input  ID_W  ignored
- s_rresp  input  2  flash read response

Behaviour:
- Reset (async, nrst=0):
  - state=IDLE, last_grant=1 (so M0 wins the first tie).
  - All m*_arready, m*_rvalid, s_arvalid and s_rready are 0.
  - Address, ID, data and rresp registers are 0.
  - Reset mid-transaction aborts to IDLE with no response. The flash controller shares nrst, so it aborts together with this block.
- States: IDLE, ADDR, WAIT, RESP.
- IDLE:
  - If exactly one mX_arvalid is high, that manager is the winner.
  - If both are high, the winner is the manager not equal to last_grant.
  - The winner's arready=1 combinationally in that same cycle; the loser's arready=0.
  - On the handshake, latch {araddr[ADDR_W-1:2],2'b00}, arid and grant index, then go to ADDR.
  - With no request, all arready=0.
- ADDR:
  - s_arvalid=1, s_araddr=latched address, s_arid=latched ID.
  - Hold until s_arready=1, then go to WAIT.
  - s_arready may lag arbitrarily, because the flash controller only accepts on its clock strobe. s_arvalid is never dropped before acceptance.
- WAIT:
  - s_rready=1.
  - On s_rvalid=1, capture s_rdata and s_rresp, then go to RESP.
- RESP:
  - The granted manager's rvalid=1, with rdata/rresp=captured values, rid=latched ID, rlast=1.
  - The other manager's rvalid=0.
  - Hold until that manager's rready=1. Then go to IDLE and set last_grant to the granted index.
- Response outputs are registered and stay stable while rvalid is high.
- New arvalid is never accepted outside IDLE; the requester stalls.
- Minimum latency:
  - Manager AR handshake to rvalid is 3 cycles plus flash latency.
  - Back-to-back service alternates M0/M1 under continuous contention.
- rlast is tied to 1.

Optional Feature:
- Macro FLASH_ARB_LAST_WORD_CACHE_EN.
- Defined:
  - A one-entry buffer holds {valid, word address, data} from the last OKAY flash response.
  - In IDLE, an accepted request whose aligned address matches a valid entry goes directly to RESP. It returns the buffered data with rresp=OKAY and the requester's ID; ADDR and WAIT are skipped.
  - The hit AR-to-rvalid latency is 1 cycle.
  - The entry is updated on every OKAY capture in WAIT. A non-OKAY response clears valid.
  - Reset clears valid.
- Undefined: every request goes to flash; no buffer logic is present.

Decomposition:
- arb_state_t (IDLE/ADDR/WAIT/RESP) and the AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) go in common_types_pkg.
- One sub-module, rr_arbiter2: 2-requester round-robin grant with last_grant register and update strobe.

Test Plan:
- Single read: M0 sends araddr 0x0000_0106, arid 3; flash returns 0xDEADBEEF.
  - Required: s_araddr=0x0000_0104; m0 gets rdata 0xDEADBEEF, rid 3, rlast 1.
  - Required: m1_rvalid stays 0 throughout.
- Tie after reset: M0 and M1 both arvalid in the same cycle.
  - Required: M0 is granted first, then M1.
  - Repeat the simultaneous requests: grants alternate M1 and M0.
- Backpressure on R: hold m1_rready=0 for 10 cycles while M1 rvalid=1.
  - Required: rdata and rid stable; no M0 arready asserted until the handshake completes.
- Slow acceptance: hold s_arready=0 for 7 cycles.
  - Required: s_arvalid and s_araddr held constant; exactly one flash transaction is issued.
- Reset mid-operation: drive nrst low during WAIT.
  - Required: all valids 0 immediately; after release, a new M1 read completes normally.
- With FLASH_ARB_LAST_WORD_CACHE_EN defined: read 0x100 twice.
  - Required: the second read returns the same data 1 cycle after AR, with s_arvalid never asserted.
  - Then a read of 0x104 goes to flash.
